// File: rtl/bank_row_reader_if.sv
// Handshake/bus bundle for bank_row_reader: request port, bank read port, chunk output stream.
// Optional READER_POPCOUNT_EN adds out_popcount to the output stream.
interface bank_row_reader_if #(
  parameter int TX_DATA_WIDTH   = 32,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int COL_ADDR_WIDTH  = 8
);
  logic                       req_valid;
  logic [BANK_ADDR_WIDTH-1:0] req_row;
  logic                       req_ready;
  logic                       read_en;
  logic [BANK_ADDR_WIDTH-1:0] owner_row_addr;
  logic [COL_ADDR_WIDTH-1:0]  col_addr;
  logic                       busy;
  logic                       ack;
  logic [TX_DATA_WIDTH-1:0]   partial_vec_out;
  logic                       out_valid;
  logic                       out_ready;
  logic [TX_DATA_WIDTH-1:0]   out_data;
  logic [COL_ADDR_WIDTH-1:0]  out_col;
  logic                       out_last;
`ifdef READER_POPCOUNT_EN
  logic [$clog2(TX_DATA_WIDTH+1)-1:0] out_popcount;
`endif

  modport master (
`ifdef READER_POPCOUNT_EN
    output out_popcount,
`endif
    input  req_valid, req_row, busy, ack, partial_vec_out, out_ready,
    output req_ready, read_en, owner_row_addr, col_addr,
    output out_valid, out_data, out_col, out_last
  );

  modport slave (
`ifdef READER_POPCOUNT_EN
    input  out_popcount,
`endif
    output req_valid, req_row, busy, ack, partial_vec_out, out_ready,
    input  req_ready, read_en, owner_row_addr, col_addr,
    input  out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/bank_row_reader.sv
// Reads one bank row as NCHUNK column chunks, one read outstanding, into a 2-entry output FIFO.
// Optional macro READER_POPCOUNT_EN adds a registered popcount of each delivered chunk.
module bank_row_reader #(
  parameter int TX_DATA_WIDTH   = 32,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int COL_ADDR_WIDTH  = 8,
  parameter int MAX_COLS        = 140
) (
  input logic               clock,
  input logic               reset,
  bank_row_reader_if.master bus
);
  localparam int          NCHUNK    = MAX_COLS / TX_DATA_WIDTH + 1;
  localparam int unsigned LAST_BITS = MAX_COLS - (NCHUNK - 1) * TX_DATA_WIDTH;
  localparam int          CHUNK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK_W-1:0]        LAST_CHUNK = CHUNK_W'(NCHUNK - 1);
  localparam logic [COL_ADDR_WIDTH-1:0] COL_STEP   = COL_ADDR_WIDTH'(TX_DATA_WIDTH);
`ifdef READER_POPCOUNT_EN
  localparam int          PC_W      = $clog2(TX_DATA_WIDTH + 1);
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FLUSH} state_t;

  typedef struct packed {
`ifdef READER_POPCOUNT_EN
    logic [PC_W-1:0]           popcount;
`endif
    logic [TX_DATA_WIDTH-1:0]  data;
    logic [COL_ADDR_WIDTH-1:0] col;
    logic                      last;
  } entry_t;

  state_t                     state_q, state_d;
  logic                       ready_en_q;
  logic [BANK_ADDR_WIDTH-1:0] row_q;
  logic [CHUNK_W-1:0]         chunk_q;
  logic [COL_ADDR_WIDTH-1:0]  col_q;
  entry_t                     mem_q [2];
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 count_q;
  logic                       is_last, fifo_free, accept, push, pop;
  logic [TX_DATA_WIDTH-1:0]   last_mask;
  entry_t                     push_entry;

  assign is_last   = (chunk_q == LAST_CHUNK);
  assign fifo_free = (count_q != 2'd2);
  assign accept    = bus.req_valid && bus.req_ready;
  assign push      = (state_q == WAIT_ACK) && bus.ack;
  assign pop       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = ISSUE;
      ISSUE:    if (bus.read_en) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.ack) state_d = is_last ? FLUSH : ISSUE;
      // Leave as soon as the FIFO drains, including the cycle of the final pop.
      FLUSH:    if (count_q == 2'd0 || (count_q == 2'd1 && pop)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ready_en_q keeps req_ready low until the first clock after reset release.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.read_en   = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready = ready_en_q;
      ISSUE:   bus.read_en   = !bus.busy && fifo_free;
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < TX_DATA_WIDTH; i++) last_mask[i] = (i < LAST_BITS);
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = is_last ? (bus.partial_vec_out & last_mask) : bus.partial_vec_out;
    push_entry.col  = col_q;
    push_entry.last = is_last;
`ifdef READER_POPCOUNT_EN
    push_entry.popcount = PC_W'($countones(push_entry.data));
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      row_q      <= '0;
      chunk_q    <= '0;
      col_q      <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        row_q   <= bus.req_row;
        chunk_q <= '0;
        col_q   <= '0;
      end else if (push && !is_last) begin
        chunk_q <= chunk_q + CHUNK_W'(1);
        col_q   <= col_q + COL_STEP;
      end
    end
  end

  // Issue is gated on a free slot, so an ack always finds room even without a pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.owner_row_addr = row_q;
  assign bus.col_addr       = col_q;
  assign bus.out_valid      = (count_q != 2'd0);
  assign bus.out_data       = mem_q[rd_ptr_q].data;
  assign bus.out_col        = mem_q[rd_ptr_q].col;
  assign bus.out_last       = bus.out_valid && mem_q[rd_ptr_q].last;
`ifdef READER_POPCOUNT_EN
  assign bus.out_popcount   = mem_q[rd_ptr_q].popcount;
`endif
endmodule

// File: tb/tb_bank_row_reader.sv
// Directed bench for bank_row_reader: bank responder model, output collector, assertion checks.
`timescale 1ns/1ps
module tb_bank_row_reader;
  localparam int TXW = 32, AW = 8, CW = 8, MAXC = 140;

  localparam logic [31:0] ROW3_EXP [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                           32'hFFFF_FFFF, 32'h0000_0FFF};
  localparam logic [31:0] ROW0_EXP [5] = '{32'hC0DE_0000, 32'hC0DE_0020, 32'hC0DE_0040,
                                           32'hC0DE_0060, 32'h0000_0080};
  localparam logic [31:0] COL_EXP  [5] = '{32'd0, 32'd32, 32'd64, 32'd96, 32'd128};
`ifdef READER_POPCOUNT_EN
  localparam logic [31:0] PC_EXP   [5] = '{32'd32, 32'd32, 32'd32, 32'd32, 32'd12};
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bank_row_reader_if #(.TX_DATA_WIDTH(TXW), .BANK_ADDR_WIDTH(AW), .COL_ADDR_WIDTH(CW)) bus ();

  bank_row_reader #(.TX_DATA_WIDTH(TXW), .BANK_ADDR_WIDTH(AW), .COL_ADDR_WIDTH(CW),
                    .MAX_COLS(MAXC)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic          bank_ack, spur_ack;
  logic [31:0]   bank_data;
  assign bus.ack             = bank_ack | spur_ack;
  assign bus.partial_vec_out = bank_data;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int rd_pulses = 0, rd_busy = 0, serviced = 0;
  int first_ack = -1, first_valid = -1, first_rd = -1, acc_cyc = 0;
  logic [31:0] q_data [$];
  logic [7:0]  q_col  [$];
  logic        q_last [$];
`ifdef READER_POPCOUNT_EN
  logic [5:0]  q_pc   [$];
`endif

  always @(posedge clock) cyc <= cyc + 1;

  // Bank contents: bits beyond column 139 read back as ones so the tail mask is exercised.
  function automatic logic [31:0] bank_word(input logic [7:0] r, input logic [7:0] c);
    if (r == 8'd3) return 32'hFFFF_FFFF;
    if (r == 8'd0) return 32'hC0DE_0000 | {24'h0, c};
    return 32'h1234_5678;
  endfunction

  initial begin
    logic [7:0] r, c;
    bank_ack  = 1'b0;
    bank_data = '0;
    forever begin
      @(posedge clock);
      if (reset && bus.read_en) begin
        r = bus.owner_row_addr;
        c = bus.col_addr;
        serviced++;
        @(posedge clock); #1;
        bank_ack  = 1'b1;
        bank_data = bank_word(r, c);
        @(posedge clock); #1;
        bank_ack  = 1'b0;
        bank_data = 32'hDEAD_BEEF;
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      if (bus.read_en) begin
        rd_pulses++;
        if (first_rd < 0) first_rd = cyc;
        if (bus.busy) rd_busy++;
      end
      if (bank_ack && first_ack < 0) first_ack = cyc;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_col.push_back(bus.out_col);
        q_last.push_back(bus.out_last);
`ifdef READER_POPCOUNT_EN
        q_pc.push_back(bus.out_popcount);
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_col.delete();
    q_last.delete();
`ifdef READER_POPCOUNT_EN
    q_pc.delete();
`endif
  endtask

  task automatic request(input logic [7:0] row);
    bus.req_valid = 1'b1;
    bus.req_row   = row;
    acc_cyc       = cyc;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (q_data.size() < n && k < 200) begin tick(); k++; end
    check(tag, 32'(q_data.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin tick(); k++; end
    check(tag, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_row(input int base, input bit row3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("r%0d_data%0d", row3 ? 3 : 0, k), q_data[base+k],
            row3 ? ROW3_EXP[k] : ROW0_EXP[k]);
      check($sformatf("r%0d_col%0d", row3 ? 3 : 0, k), {24'h0, q_col[base+k]}, COL_EXP[k]);
      check($sformatf("r%0d_last%0d", row3 ? 3 : 0, k), 32'(q_last[base+k]), 32'(k == 4));
`ifdef READER_POPCOUNT_EN
      if (row3) check($sformatf("r3_pc%0d", k), {26'h0, q_pc[base+k]}, PC_EXP[k]);
`endif
    end
  endtask

  task automatic check_reset_vals(input string pre);
    check({pre, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({pre, "_read_en"},   32'(bus.read_en),   32'd0);
    check({pre, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({pre, "_out_last"},  32'(bus.out_last),  32'd0);
    check({pre, "_owner"},     {24'h0, bus.owner_row_addr}, 32'd0);
    check({pre, "_col_addr"},  {24'h0, bus.col_addr}, 32'd0);
    check({pre, "_out_data"},  bus.out_data, 32'd0);
    check({pre, "_out_col"},   {24'h0, bus.out_col}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, k;
    bus.req_valid = 1'b0;
    bus.req_row   = '0;
    bus.busy      = 1'b0;
    bus.out_ready = 1'b0;
    spur_ack      = 1'b0;

    // Reset values, and req_ready held low until the first clock after release.
    #12;
    check_reset_vals("rst");
    tick();
    reset = 1'b1;
    check("ready_at_release", 32'(bus.req_ready), 32'd0);
    tick();
    check("ready_after_clock", 32'(bus.req_ready), 32'd1);

    // Spurious ack in IDLE.
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    tick();
    check("spur_out_valid", 32'(bus.out_valid), 32'd0);

    // Plain row 3 read with free-flowing output.
    bus.out_ready = 1'b1;
    clear_q();
    first_ack = -1; first_valid = -1; first_rd = -1;
    request(8'd3);
    wait_got(5, "rowA_count");
    check_row(0, 1'b1);
    check("rd_after_accept", 32'(first_rd > acc_cyc), 32'd1);
    check("valid_lat", 32'(first_valid), 32'(first_ack + 1));
    wait_idle("rowA_idle");

    // Request held during a row read is not taken until the row fully drains.
    clear_q();
    bus.req_valid = 1'b1;
    bus.req_row   = 8'd3;
    tick();
    bus.req_row   = 8'd0;
    check("busy_req_ready", 32'(bus.req_ready), 32'd0);
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin tick(); k++; end
    check("held_req_drained", 32'(q_data.size()), 32'd5);
    tick();
    bus.req_valid = 1'b0;
    wait_got(10, "rowB_count");
    check_row(0, 1'b1);
    check_row(5, 1'b0);
    wait_idle("rowB_idle");

    // Bank busy for 10 cycles after the request.
    clear_q();
    bus.busy = 1'b1;
    base = rd_pulses;
    request(8'd3);
    repeat (10) tick();
    check("busy_no_read", 32'(rd_pulses - base), 32'd0);
    bus.busy = 1'b0;
    wait_got(5, "busy_count");
    check("busy_reads", 32'(rd_pulses - base), 32'd5);
    check("read_while_busy", 32'(rd_busy), 32'd0);
    check_row(0, 1'b1);
    wait_idle("busy_idle");

    // Output stalled: FIFO fills after two reads, then drains in order.
    clear_q();
    bus.out_ready = 1'b0;
    base = rd_pulses;
    request(8'd3);
    repeat (30) tick();
    check("stall_reads", 32'(rd_pulses - base), 32'd2);
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    check("stall_no_pop", 32'(q_data.size()), 32'd0);
    bus.out_ready = 1'b1;
    wait_got(5, "stall_count");
    check("stall_total_reads", 32'(rd_pulses - base), 32'd5);
    check_row(0, 1'b1);
    wait_idle("stall_idle");

    // Reset while waiting on the second chunk's ack; the late ack lands after release.
    base = rd_pulses;
    request(8'd3);
    k = 0;
    while (rd_pulses - base < 2 && k < 50) begin tick(); k++; end
    check("mid_second_read", 32'(rd_pulses - base), 32'd2);
    clear_q();
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    #1;
    reset = 1'b1;
    repeat (5) tick();
    check("late_ack_valid", 32'(bus.out_valid), 32'd0);
    check("late_ack_no_data", 32'(q_data.size()), 32'd0);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    request(8'd0);
    wait_got(5, "row0_count");
    check_row(0, 1'b0);
    wait_idle("row0_idle");

    check("one_outstanding", 32'(serviced), 32'(rd_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_row_reader.md
BANK_ROW_READER -- requirements
Module: bank_row_reader

Interface
REQ-001 Parameter: TX_DATA_WIDTH, 32, bits per bank transfer chunk (from `TX_DATA_WIDTH).
REQ-002 Parameter: BANK_ADDR_WIDTH, 8, row address width (from `BANK_ADDR_WIDTH).
REQ-003 Parameter: COL_ADDR_WIDTH, 8, column address width (from `COL_ADDR_WIDTH).
REQ-004 Parameter: MAX_COLS, 140, grid columns per row (from `MAX_COLS).
REQ-005 Port: clock  in  1  single clock; all logic on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: req_valid  in  1  row read request; req_row  in  BANK_ADDR_WIDTH  row to read; req_ready  out  1  request accepted when high with req_valid.
REQ-008 Port: read_en  out  1  bank read strobe; owner_row_addr  out  BANK_ADDR_WIDTH; col_addr  out  COL_ADDR_WIDTH.
REQ-009 Port: busy  in  1  bank controller busy; ack  in  1  one-cycle read-complete pulse; partial_vec_out  in  TX_DATA_WIDTH  read data, valid in the ack cycle.
REQ-010 Port: out_valid  out  1; out_ready  in  1; out_data  out  TX_DATA_WIDTH; out_col  out  COL_ADDR_WIDTH  chunk start column; out_last  out  1  final chunk of row.

Function
REQ-011 NCHUNK = MAX_COLS/TX_DATA_WIDTH + 1 (integer division); chunk k reads col_addr = k*TX_DATA_WIDTH (defaults: 5 chunks, cols 0,32,64,96,128).
REQ-012 FSM states IDLE, ISSUE, WAIT_ACK, FLUSH; req_ready = 1 only in IDLE.
REQ-013 IDLE: req_valid=1 latches req_row, chunk index=0, next state ISSUE.
REQ-014 ISSUE: when busy=0 and FIFO free slots >= 1, assert read_en for exactly one cycle with owner_row_addr=latched row, col_addr=chunk column, then WAIT_ACK; else hold with read_en=0.
REQ-015 WAIT_ACK: on ack=1, push {partial_vec_out masked, column, last} into FIFO; if last chunk go FLUSH, else increment chunk index and go ISSUE.
REQ-016 At most one bank read outstanding at any time.
REQ-017 Output FIFO: 2 entries; out_valid = not empty; pop when out_valid & out_ready; push and pop in the same cycle are both honoured.
REQ-018 Last chunk: data bits at index >= MAX_COLS - (NCHUNK-1)*TX_DATA_WIDTH forced to 0 (default: bits 12..31 zero); other chunks unmasked.
REQ-019 out_last = 1 only for the final chunk of the row.
REQ-020 FLUSH: return to IDLE when FIFO empty (including the cycle it empties by pop).
REQ-021 ack while not in WAIT_ACK is ignored; no push.
REQ-022 Request latency: first read_en no earlier than the cycle after acceptance; first out_valid the cycle after the first ack.
REQ-023 out_ready held low stalls issuing once FIFO full; no data lost or duplicated.

Reset
REQ-024 reset=0 asynchronously forces: state IDLE, FIFO empty, read_en=0, out_valid=0, out_last=0, req_ready=0 until first clock after release, owner_row_addr=0, col_addr=0, out_data=0, out_col=0.
REQ-025 Reset mid-row discards FIFO contents and outstanding read; a late ack after release is ignored per REQ-021.

Configuration
REQ-026 Macro READER_POPCOUNT_EN: when defined, port out_popcount  out  $clog2(TX_DATA_WIDTH+1) carries the count of 1 bits in out_data (post-mask), registered alongside the FIFO entry; when undefined, port and logic absent, all other behaviour identical.

Verification
REQ-027 Bank preloaded row 3 = all '@' (140 ones); request row 3, out_ready=1 -> 5 chunks, cols 0,32,64,96,128, data 0xFFFFFFFF x4 then 0x00000FFF, out_last only on the fifth.
REQ-028 busy=1 for 10 cycles after request -> read_en stays 0 until busy falls, then exactly one read_en pulse per chunk.
REQ-029 out_ready=0 throughout -> exactly 2 reads issued, FIFO full, no further read_en; raise out_ready -> remaining 3 chunks delivered in order, none lost.
REQ-030 Spurious ack in IDLE -> out_valid stays 0; req_valid during row read -> req_ready=0, request not taken until FLUSH completes.
REQ-031 reset asserted during WAIT_ACK of chunk 2 -> all outputs at reset values immediately; new request for row 0 after release returns correct row 0 data.
REQ-032 With READER_POPCOUNT_EN, row 3 as in REQ-027 -> out_popcount 32,32,32,32,12.
